cnn_pool_out: RTL and testbench
===============================

// Module: cnn_pool_out
// PURPOSE
//  Downstream stage of the cnn core. Consumes the core's out/o_en sample stream and
//  max-pools POOL consecutive valid samples into one result. Results are buffered in
//  a DEPTH-entry FIFO and presented on a valid/ready interface to the readout logic.
//  The cnn core has no backpressure, so a result that arrives while the FIFO is full
//  is dropped and flagged.
// PARAMETERS
//  DW     8   data width of samples and results (unsigned)
//  POOL   4   valid samples per pooling window, >=2
//  DEPTH  4   FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       async reset, active-low (0 = reset)
//  in_data    in   DW      sample from cnn core (its out)
//  in_en      in   1       in_data valid this cycle (its o_en)
//  flush      in   1       sync: discard partial window; FIFO untouched
//  out_data   out  DW      FIFO head, valid when out_valid=1
//  out_valid  out  1       FIFO not empty
//  out_ready  in   1       consumer accepts head this cycle
//  level      out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//  overflow   out  1       sticky: a result was dropped; cleared only by rst
// BEHAVIOUR
//  Reset (rst=0, async): cnt=0, max_r=0, FIFO empty (wr/rd ptr=0),
//   out_valid=0, out_data=0, level=0, overflow=0.
//  Window: cnt counts 0..POOL-1, advancing only on in_en=1.
//   - in_en & cnt==0: max_r<=in_data.
//   - in_en & 0<cnt<POOL-1: max_r<=max(max_r,in_data) (unsigned compare).
//   - in_en & cnt==POOL-1: res=max(max_r,in_data) is pushed; cnt<=0.
//   - in_en=0: cnt and max_r hold. Gaps between samples are allowed.
//  flush=1: cnt<=0 that cycle. flush wins over a coincident in_en; that sample,
//   including a window-completing one, is discarded with no push.
//  Latency: out_valid rises the cycle after the edge that captured the last sample
//   of a window, if the FIFO was empty.
//  FIFO: show-ahead; out_data = mem[rd_ptr] combinationally, 0 when empty.
//   - Pop when out_valid & out_ready.
//   - Push accepted when level<DEPTH, or level==DEPTH with a pop in the same cycle.
//   - Push+pop in the same cycle: level unchanged and ordering preserved.
//     When empty, push+pop cannot occur because out_valid=0.
//   - Push refused (full, no pop): result dropped, overflow<=1, and the window
//     still restarts (cnt<=0).
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//     level = wr_cnt - rd_cnt, using extra-bit counters.
//   - out_ready while empty: no effect.
//  Reset mid-window or with a full FIFO: all contents are lost immediately
//   (async). The first window after release starts at cnt=0.
//  No X on outputs after reset. out_data is stable while out_valid=1 and
//   out_ready=0.
// TESTING
//  T1 reset: rst=0 at any time, including mid-window -> all outputs 0 async,
//     and the next 4 samples form a fresh window.
//  T2 basic pool: in_en=1 for 4 cycles with 16,32,8,5, out_ready=1
//     -> one result 32, out_valid high 1 cycle after the 4th sample edge.
//  T3 gaps and flush: samples 16, idle 3 cycles, 200, flush, then 1,2,3,4
//     -> single result 4 (200 discarded). Also flush coincident with the 4th
//     sample -> no result.
//  T4 full/overflow: out_ready=0, 5 windows of maxima 10,20,30,40,50
//     -> level=4, overflow=1, drain order 10,20,30,40.
//  T5 push+pop at full: level=4, out_ready=1 in the cycle a window completes
//     -> level stays 4, overflow stays 0, new result is last in drain order.
//  T6 wrap and extremes: stream 3*DEPTH windows with values 0 and 255,
//     random out_ready -> outputs match a reference-model queue, no loss
//     when not full.

Source files
------------

// File: rtl/cnn_pool_out.sv
// Max-pooling output stage for the cnn core: pools POOL valid samples into one
// result and buffers results in a show-ahead FIFO with a valid/ready read side.
module cnn_pool_out #(
    parameter int DW    = 8,
    parameter int POOL  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_en,
    input  logic                     flush,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(POOL);
    localparam logic [CW-1:0] CNT_LAST   = CW'(POOL - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [CW-1:0] cnt;
    logic [DW-1:0] max_r;
    logic [DW-1:0] res;
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_cnt;
    logic [AW:0]   rd_cnt;
    logic          win_done;
    logic          pop;
    logic          push;
    logic          full;

    // Running maximum including the current sample; unsigned compare.
    assign res = (in_data > max_r) ? in_data : max_r;

    // flush has priority: a window-completing sample under flush is discarded.
    assign win_done  = in_en & ~flush & (cnt == CNT_LAST);
    assign level     = wr_cnt - rd_cnt;
    assign full      = (level == LEVEL_FULL);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO can still take a result when the head leaves in the same cycle.
    assign push      = win_done & (~full | pop);
    assign out_data  = out_valid ? mem[rd_cnt[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            max_r <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (in_en) begin
            cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            max_r <= (cnt == '0) ? in_data : res;
        end
    end

    // NOTE: extra-bit counters distinguish full from empty; level is their difference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_cnt <= wr_cnt + 1'b1;
            if (pop)  rd_cnt <= rd_cnt + 1'b1;
            if (win_done & ~push) overflow <= 1'b1;
        end
    end

    // NOTE: storage is not reset; out_data is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_cnt[AW-1:0]] <= res;
    end

endmodule

// File: tb/tb_cnn_pool_out.sv
// Directed and model-checked bench for cnn_pool_out (DW=8, POOL=4, DEPTH=4).
module tb_cnn_pool_out;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] level;
    logic       overflow;

    int total  = 0;
    int passed = 0;

    cnn_pool_out #(.DW(8), .POOL(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_en     (in_en),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input int v, input int d, input int l);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_level"}, 32'(level),     32'(l));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [7:0] d);
        in_data = d;
        in_en   = 1'b1;
        tick();
        in_en   = 1'b0;
    endtask

    task automatic window(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        sample(a);
        sample(b);
        sample(c);
        sample(d);
    endtask

    int exp4[4] = '{10, 20, 30, 40};
    int exp5[4] = '{2, 3, 4, 9};
    int q[$];
    int mcnt = 0;
    int mmax = 0;
    int wins = 0;
    bit movf = 1'b0;

    initial begin
        // Reset
        #2 rst = 1'b0;
        #1;
        check_out("rst", 0, 0, 0);
        check("rst_ovf", 32'(overflow), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic pool
        out_ready = 1'b1;
        sample(8'd16);
        sample(8'd32);
        sample(8'd8);
        check("t2_pre_level", 32'(level), 32'd0);
        sample(8'd5);
        check_out("t2_res", 1, 32, 1);
        tick();
        check_out("t2_pop", 0, 0, 0);

        // Gaps and flush
        out_ready = 1'b0;
        sample(8'd16);
        tick();
        tick();
        tick();
        sample(8'd200);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        window(8'd1, 8'd2, 8'd3, 8'd4);
        check_out("t3_res", 1, 4, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_out("t3_pop", 0, 0, 0);
        sample(8'd9);
        sample(8'd9);
        sample(8'd9);
        in_data = 8'd9;
        in_en   = 1'b1;
        flush   = 1'b1;
        tick();
        in_en = 1'b0;
        flush = 1'b0;
        check_out("t3_flush4", 0, 0, 0);
        window(8'd1, 8'd1, 8'd1, 8'd7);
        check_out("t3_fresh", 1, 7, 1);
        tick();
        check("t3_hold", 32'(out_data), 32'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Full / overflow
        window(8'd1, 8'd10, 8'd3, 8'd2);
        window(8'd20, 8'd0, 8'd0, 8'd0);
        window(8'd5, 8'd30, 8'd5, 8'd5);
        window(8'd0, 8'd0, 8'd0, 8'd40);
        check("t4_ovf_before", 32'(overflow), 32'd0);
        window(8'd50, 8'd49, 8'd48, 8'd47);
        check_out("t4_full", 1, 10, 4);
        check("t4_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_out("t4_drain", 1, exp4[i], 4 - i);
            tick();
        end
        out_ready = 1'b0;
        check_out("t4_empty", 0, 0, 0);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Async reset mid-window with data in the FIFO
        window(8'd0, 8'd0, 8'd0, 8'd60);
        sample(8'd100);
        sample(8'd100);
        #2 rst = 1'b0;
        #1;
        check_out("t1_async", 0, 0, 0);
        check("t1_ovf", 32'(overflow), 32'd0);
        #3 rst = 1'b1;
        tick();
        sample(8'd5);
        sample(8'd6);
        check("t1_no_stale", 32'(level), 32'd0);
        sample(8'd7);
        sample(8'd8);
        check_out("t1_fresh", 1, 8, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Push and pop together while full
        window(8'd1, 8'd1, 8'd1, 8'd1);
        window(8'd2, 8'd2, 8'd2, 8'd2);
        window(8'd3, 8'd3, 8'd3, 8'd3);
        window(8'd4, 8'd4, 8'd4, 8'd4);
        check_out("t5_full", 1, 1, 4);
        sample(8'd9);
        sample(8'd9);
        sample(8'd9);
        in_data   = 8'd9;
        in_en     = 1'b1;
        out_ready = 1'b1;
        tick();
        in_en     = 1'b0;
        out_ready = 1'b0;
        check_out("t5_pushpop", 1, 2, 4);
        check("t5_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_drain", 32'(out_data), 32'(exp5[i]));
            tick();
        end
        out_ready = 1'b0;
        check_out("t5_empty", 0, 0, 0);

        // Random stream of extremes against a reference queue
        for (int cyc = 0; cyc < 600 && wins < 12; cyc++) begin
            automatic bit e     = ($urandom_range(3) != 0);
            automatic int d     = ($urandom_range(2) == 0) ? 255 : 0;
            automatic bit r     = ($urandom_range(1) == 1);
            automatic bit pop_m = r && (q.size() != 0);
            automatic bit done  = e && (mcnt == 3);
            automatic int res_m = (mcnt == 0) ? d : ((d > mmax) ? d : mmax);
            automatic bit acc   = done && ((q.size() < 4) || pop_m);
            in_en     = e;
            in_data   = 8'(d);
            out_ready = r;
            if (e) begin
                mmax = res_m;
                mcnt = done ? 0 : mcnt + 1;
            end
            if (done) wins++;
            if (done && !acc) movf = 1'b1;
            tick();
            if (pop_m) void'(q.pop_front());
            if (acc) q.push_back(res_m);
            check_out("t6", (q.size() != 0) ? 1 : 0, (q.size() != 0) ? q[0] : 0, q.size());
            check("t6_ovf", 32'(overflow), 32'(movf));
        end
        in_en = 1'b0;
        check("t6_windows", 32'(wins), 32'd12);
        out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            tick();
            void'(q.pop_front());
            check_out("t6_drain", (q.size() != 0) ? 1 : 0, (q.size() != 0) ? q[0] : 0, q.size());
        end
        out_ready = 1'b0;
        check("t6_end_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
